// File: rtl/calc_pkg.sv
// Shared constants for the calc front end: clock rate, debounce window and
// operation-select bit positions.
package calc_pkg;
  localparam int CLK_HZ          = 100_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int SYNC_STAGES     = 2;

  // Index of each button inside the conditioner's debounced button vector.
  localparam int OP_BIT_R   = 0;
  localparam int OP_BIT_C   = 1;
  localparam int OP_BIT_L   = 2;
  localparam int BTN_BIT_D  = 3;
  localparam int NUM_BTNS   = 4;
  localparam int SW_W       = 16;
endpackage

// File: rtl/btn_debounce.sv
// One-bit synchronizer followed by a saturating-window debouncer; the output
// flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = calc_pkg::SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   w_sync;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Any agreement restarts the window, so short bounces never land.
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// Debounces the four buttons, synchronizes the switches and emits one
// op_valid strobe per btnd press with a coherent snapshot of selects/switches.
module btn_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = calc_pkg::DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = calc_pkg::SYNC_STAGES
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic        op_valid,
  output logic        op_l,
  output logic        op_c,
  output logic        op_r,
  output logic [15:0] op_sw
);
  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_stable;
  logic [SYNC_STAGES-1:0][SW_W-1:0] r_sw_sync;
  logic [SW_W-1:0]     w_sw;
  logic                r_btnd_prev;
  logic                w_rise;
  logic                r_op_valid;
  logic                r_op_l, r_op_c, r_op_r;
  logic [SW_W-1:0]     r_op_sw;

  always_comb begin
    w_raw            = '0;
    w_raw[OP_BIT_L]  = btnl;
    w_raw[OP_BIT_C]  = btnc;
    w_raw[OP_BIT_R]  = btnr;
    w_raw[BTN_BIT_D] = btnd;
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .clk     (clk),
      .rst     (btnu),
      .i_raw   (w_raw[i]),
      .o_stable(w_stable[i])
    );
  end

  assign w_sw   = r_sw_sync[SYNC_STAGES-1];
  assign w_rise = w_stable[BTN_BIT_D] & ~r_btnd_prev;

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      r_sw_sync   <= '0;
      r_btnd_prev <= 1'b0;
      r_op_valid  <= 1'b0;
      r_op_l      <= 1'b0;
      r_op_c      <= 1'b0;
      r_op_r      <= 1'b0;
      r_op_sw     <= '0;
    end else begin
      r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], sw};
      r_btnd_prev <= w_stable[BTN_BIT_D];
      r_op_valid  <= w_rise;
      // Snapshot is taken from the rise cycle itself; no extra alignment.
      if (w_rise) begin
        r_op_l  <= w_stable[OP_BIT_L];
        r_op_c  <= w_stable[OP_BIT_C];
        r_op_r  <= w_stable[OP_BIT_R];
        r_op_sw <= w_sw;
      end
    end
  end

  assign op_valid = r_op_valid;
  assign op_l     = r_op_l;
  assign op_c     = r_op_c;
  assign op_r     = r_op_r;
  assign op_sw    = r_op_sw;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;
  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = DC + SS;

  logic        clk = 1'b0;
  logic        btnu = 1'b0, btnl = 1'b0, btnc = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic [15:0] sw = 16'h0;
  logic        op_valid, op_l, op_c, op_r;
  logic [15:0] op_sw;

  btn_conditioner #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .btnu(btnu), .btnl(btnl), .btnc(btnc), .btnr(btnr),
    .btnd(btnd), .sw(sw), .op_valid(op_valid), .op_l(op_l), .op_c(op_c),
    .op_r(op_r), .op_sw(op_sw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        l, c, r;
    logic [15:0] sw;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after btnd is raised; the next rising edge is edge 0.
  task automatic push_press();
    exp_t e;
    e.cyc = cyc + 1 + LAT;
    e.l   = btnl;
    e.c   = btnc;
    e.r   = btnr;
    e.sw  = sw;
    q.push_back(e);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_op_valid"}, op_valid, 0);
    chk({tag, "_op_l"}, op_l, last.l);
    chk({tag, "_op_c"}, op_c, last.c);
    chk({tag, "_op_r"}, op_r, last.r);
    chk({tag, "_op_sw"}, op_sw, last.sw);
  endtask

  task automatic clear_last();
    last.cyc = 0; last.l = 0; last.c = 0; last.r = 0; last.sw = 16'h0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (op_valid) begin
      if (q.size() == 0) begin
        chk("spurious_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_op_l", op_l, e.l);
        chk("strobe_op_c", op_c, e.c);
        chk("strobe_op_r", op_r, e.r);
        chk("strobe_op_sw", op_sw, e.sw);
        last = e;
      end
    end
  end

  initial begin
    clear_last();
    // Reset with arbitrary inputs applied
    #2;
    btnl = 1; btnc = 1; btnr = 1; btnd = 1; sw = 16'hFFFF;
    btnu = 1;
    #1;
    chk_hold("reset_imm");
    step(1);
    btnd = 0;
    btnu = 0;
    step(10);
    chk_hold("reset_rel");

    // Clean press
    btnl = 0; btnc = 1; btnr = 0; sw = 16'h354A;
    step(10);
    btnd = 1;
    push_press();
    step(20);
    chk_hold("clean_held");
    btnd = 0;
    step(12);
    chk_hold("clean_release");

    // Bounce then settle high
    for (int i = 0; i < 6; i++) begin
      btnd = (i % 2 == 0);
      step(1);
    end
    btnd = 1;
    push_press();
    step(20);
    btnd = 0;
    step(12);
    chk_hold("bounce");

    // Glitch of DEBOUNCE_CYCLES-1 cycles must be rejected
    btnd = 1;
    step(DC - 1);
    btnd = 0;
    step(20);
    chk_hold("glitch");

    // Second operation, selects and switches change with the press
    step(10);
    sw = 16'h1234; btnc = 1; btnr = 1; btnd = 1;
    push_press();
    step(20);
    chk_hold("second_held");
    btnd = 0;
    step(12);

    // Reset mid-count with btnd held across release
    btnd = 1;
    step(3);
    btnu = 1;
    #1;
    clear_last();
    chk_hold("midrst_imm");
    @(posedge clk);
    #1;
    btnu = 0;
    push_press();
    step(20);
    chk_hold("midrst_after");
    btnd = 0;
    step(12);
    chk_hold("final");

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
